// File: rtl/alu_ctrl_issue.sv
// ID/EX issue slot for the datapath ALU: decodes a WISC instruction into the
// ALU control vector and holds it in a stallable, flushable pipeline register.
module alu_ctrl_issue #(
    parameter int          DATA_W = 16,
    parameter logic [4:0]  NOP_OP = 5'b00100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] instr,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [4:0]        alu_op,
    output logic              inv_a,
    output logic              inv_b,
    output logic              cin,
    output logic              sign,
    output logic              b_imm,
    output logic              a_zero,
    output logic [DATA_W-1:0] ex_imm,
    output logic              illegal
);

    typedef struct packed {
        logic [4:0]        op;
        logic              inv_a;
        logic              inv_b;
        logic              cin;
        logic              sign;
        logic              b_imm;
        logic              a_zero;
        logic              illegal;
        logic [DATA_W-1:0] imm;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{op: NOP_OP, inv_a: 1'b0, inv_b: 1'b0, cin: 1'b0,
                                 sign: 1'b1, b_imm: 1'b0, a_zero: 1'b0,
                                 illegal: 1'b0, imm: '0};

    logic [4:0]        opcode;
    logic [1:0]        funct;
    logic [DATA_W-1:0] imm5_s, imm5_z, imm_sh, imm8_s, imm8_z;
    logic              unused_bits;

    assign opcode      = instr[15:11];
    assign funct       = instr[1:0];
    assign imm5_s      = {{(DATA_W-5){instr[4]}}, instr[4:0]};
    assign imm5_z      = {{(DATA_W-5){1'b0}}, instr[4:0]};
    assign imm_sh      = {{(DATA_W-4){1'b0}}, instr[3:0]};
    assign imm8_s      = {{(DATA_W-8){instr[7]}}, instr[7:0]};
    assign imm8_z      = {{(DATA_W-8){1'b0}}, instr[7:0]};
    assign unused_bits = ^instr[10:8];

    ctrl_t ctrl_d, ctrl_q;
    logic  ex_valid_d, ex_valid_q;

    // Operand-B forms: immediate ops set b_imm and pick their extension here.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch.
        ctrl_d = BUBBLE;
        case (opcode)
            5'b01000: begin ctrl_d.op = 5'b00100; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm5_s; end
            5'b01001: begin
                ctrl_d.op = 5'b00100; ctrl_d.inv_a = 1'b1; ctrl_d.cin = 1'b1;
                ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm5_s;
            end
            5'b01010: begin ctrl_d.op = 5'b00110; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm5_z; end
            5'b01011: begin
                ctrl_d.op = 5'b00111; ctrl_d.inv_b = 1'b1;
                ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm5_z;
            end
            5'b10100: begin ctrl_d.op = 5'b00000; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm_sh; end
            5'b10101: begin ctrl_d.op = 5'b00001; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm_sh; end
            5'b10110: begin ctrl_d.op = 5'b01000; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm_sh; end
            5'b10111: begin ctrl_d.op = 5'b00011; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm_sh; end
            5'b10000, 5'b10001, 5'b10011: begin
                ctrl_d.op = 5'b00100; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm5_s;
            end
            5'b11001: ctrl_d.op = 5'b01001;
            5'b11011: begin
                case (funct)
                    2'b00: ctrl_d.op = 5'b00100;
                    2'b01: begin ctrl_d.op = 5'b00100; ctrl_d.inv_a = 1'b1; ctrl_d.cin = 1'b1; end
                    2'b10: ctrl_d.op = 5'b00110;
                    default: begin ctrl_d.op = 5'b00111; ctrl_d.inv_b = 1'b1; end
                endcase
            end
            5'b11010: begin
                case (funct)
                    2'b00: ctrl_d.op = 5'b00000;
                    2'b01: ctrl_d.op = 5'b00001;
                    2'b10: ctrl_d.op = 5'b01000;
                    default: ctrl_d.op = 5'b00011;
                endcase
            end
            5'b11100: ctrl_d.op = 5'b01010;
            5'b11101: ctrl_d.op = 5'b01011;
            5'b11110: ctrl_d.op = 5'b01100;
            5'b11111: begin ctrl_d.op = 5'b01101; ctrl_d.sign = 1'b0; end
            5'b11000: begin
                ctrl_d.op = 5'b00101; ctrl_d.a_zero = 1'b1;
                ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm8_s;
            end
            5'b10010: begin ctrl_d.op = 5'b10000; ctrl_d.b_imm = 1'b1; ctrl_d.imm = imm8_z; end
            5'b01100, 5'b01101, 5'b01110, 5'b01111,
            5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b00000, 5'b00001, 5'b00010, 5'b00011: ctrl_d = BUBBLE;
            default: ctrl_d.illegal = 1'b1;
        endcase
        if (!id_valid) begin
            ctrl_d = BUBBLE;
        end
    end

    assign ex_valid_d = id_valid;

    // Flush outranks stall so a killed slot never survives a held pipeline.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst || flush) begin
            ex_valid_q <= 1'b0;
            ctrl_q     <= BUBBLE;
        end else if (!stall) begin
            ex_valid_q <= ex_valid_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign ex_valid = ex_valid_q;
    assign alu_op   = ctrl_q.op;
    assign inv_a    = ctrl_q.inv_a;
    assign inv_b    = ctrl_q.inv_b;
    assign cin      = ctrl_q.cin;
    assign sign     = ctrl_q.sign;
    assign b_imm    = ctrl_q.b_imm;
    assign a_zero   = ctrl_q.a_zero;
    assign ex_imm   = ctrl_q.imm;
    assign illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: mnemonic-level reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst, id_valid, stall, flush;
    logic [15:0] instr;
    logic        ex_valid, inv_a, inv_b, cin, sign, b_imm, a_zero, illegal;
    logic [4:0]  alu_op;
    logic [15:0] ex_imm;

    int checks   = 0;
    int failures = 0;
    bit done     = 1'b0;

    alu_ctrl_issue #(.DATA_W(16), .NOP_OP(5'b00100)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr),
        .stall(stall), .flush(flush), .ex_valid(ex_valid), .alu_op(alu_op),
        .inv_a(inv_a), .inv_b(inv_b), .cin(cin), .sign(sign), .b_imm(b_imm),
        .a_zero(a_zero), .ex_imm(ex_imm), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [4:0]  op;
        logic        ia, ib, ci, sg, bi, az, il;
        logic [15:0] imm;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic string mnemonic(input logic [15:0] ins);
        logic [1:0] f;
        f = ins[1:0];
        case (ins[15:11])
            5'b01000: return "ADDI";
            5'b01001: return "SUBI";
            5'b01010: return "XORI";
            5'b01011: return "ANDNI";
            5'b10100: return "ROLI";
            5'b10101: return "SLLI";
            5'b10110: return "RORI";
            5'b10111: return "SRLI";
            5'b10000: return "ST";
            5'b10001: return "LD";
            5'b10011: return "STU";
            5'b11001: return "BTR";
            5'b11011: return (f == 2'd0) ? "ADD" : (f == 2'd1) ? "SUB" : (f == 2'd2) ? "XOR" : "ANDN";
            5'b11010: return (f == 2'd0) ? "ROL" : (f == 2'd1) ? "SLL" : (f == 2'd2) ? "ROR" : "SRL";
            5'b11100: return "SEQ";
            5'b11101: return "SLT";
            5'b11110: return "SLE";
            5'b11111: return "SCO";
            5'b11000: return "LBI";
            5'b10010: return "SLBI";
            default:  return "CTRL";
        endcase
    endfunction

    function automatic exp_t model_decode(input logic v, input logic [15:0] ins);
        exp_t  e;
        string mn;
        e    = '0;
        e.op = 5'd4;
        e.sg = 1'b1;
        if (!v) return e;
        mn  = mnemonic(ins);
        e.v = 1'b1;
        case (mn)
            "XOR", "XORI":   e.op = 5'd6;
            "ANDN", "ANDNI": e.op = 5'd7;
            "ROL", "ROLI":   e.op = 5'd0;
            "SLL", "SLLI":   e.op = 5'd1;
            "ROR", "RORI":   e.op = 5'd8;
            "SRL", "SRLI":   e.op = 5'd3;
            "BTR":           e.op = 5'd9;
            "SEQ":           e.op = 5'd10;
            "SLT":           e.op = 5'd11;
            "SLE":           e.op = 5'd12;
            "SCO":           e.op = 5'd13;
            "LBI":           e.op = 5'd5;
            "SLBI":          e.op = 5'd16;
            default:         e.op = 5'd4;
        endcase
        e.ia = (mn == "SUB" || mn == "SUBI");
        e.ci = e.ia;
        e.ib = (mn == "ANDN" || mn == "ANDNI");
        e.sg = (mn != "SCO");
        e.az = (mn == "LBI");
        // Immediate value by instruction kind; anything with an immediate uses it as B.
        case (mn)
            "ADDI", "SUBI", "LD", "ST", "STU": e.imm = 16'($signed(ins[4:0]));
            "XORI", "ANDNI":                  e.imm = 16'(ins[4:0]);
            "ROLI", "SLLI", "RORI", "SRLI":   e.imm = 16'(ins[3:0]);
            "LBI":                            e.imm = 16'($signed(ins[7:0]));
            "SLBI":                           e.imm = 16'(ins[7:0]);
            default:                          e.imm = 16'd0;
        endcase
        e.bi = (e.imm != 16'd0) || (mn inside {"ADDI", "SUBI", "LD", "ST", "STU", "XORI",
                "ANDNI", "ROLI", "SLLI", "RORI", "SRLI", "LBI", "SLBI"});
        return e;
    endfunction

    exp_t model = model_decode(1'b0, 16'h0000);

    always @(posedge clk) begin
        if (rst || flush) model = model_decode(1'b0, 16'h0000);
        else if (!stall)  model = model_decode(id_valid, instr);
        #1;
        if (!done)
            check("model", {3'b0, ex_valid, alu_op, inv_a, inv_b, cin, sign, b_imm, a_zero,
                            illegal, ex_imm}, {3'b0, model});
    end

    task automatic step(input logic r, input logic v, input logic [15:0] ins,
                        input logic st, input logic fl);
        @(negedge clk);
        rst = r; id_valid = v; instr = ins; stall = st; flush = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b1; instr = 16'hD800; stall = 1'b0; flush = 1'b0;
        @(posedge clk); #2;
        check("rst1_valid", 32'(ex_valid), 0);
        check("rst1_op", 32'(alu_op), 32'h04);
        check("rst1_imm", 32'(ex_imm), 0);
        step(1'b1, 1'b1, 16'hD800, 1'b1, 1'b0);
        check("rst2_valid", 32'(ex_valid), 0);
        check("rst2_op", 32'(alu_op), 32'h04);
        check("rst2_imm", 32'(ex_imm), 0);

        step(1'b0, 1'b1, 16'h49FF, 1'b0, 1'b0);
        check("subi_op", 32'(alu_op), 32'h04);
        check("subi_flags", {28'b0, inv_a, cin, b_imm, inv_b}, 32'hE);
        check("subi_imm", 32'(ex_imm), 32'hFFFF);

        step(1'b0, 1'b1, 16'hC080, 1'b0, 1'b0);
        check("lbi_op", 32'(alu_op), 32'h05);
        check("lbi_az", 32'(a_zero), 1);
        check("lbi_imm", 32'(ex_imm), 32'hFF80);
        step(1'b0, 1'b1, 16'h9080, 1'b0, 1'b0);
        check("slbi_op", 32'(alu_op), 32'h10);
        check("slbi_imm", 32'(ex_imm), 32'h0080);

        step(1'b0, 1'b1, 16'hD002, 1'b0, 1'b0);
        check("ror_op", 32'(alu_op), 32'h08);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 16'h501F, 1'b1, 1'b0);
            check("stall_hold_op", 32'(alu_op), 32'h08);
        end
        step(1'b0, 1'b1, 16'h501F, 1'b0, 1'b0);
        check("xori_op", 32'(alu_op), 32'h06);
        check("xori_imm", 32'(ex_imm), 32'h001F);

        step(1'b0, 1'b1, 16'hD800, 1'b0, 1'b0);
        check("add_valid", 32'(ex_valid), 1);
        step(1'b0, 1'b1, 16'hD800, 1'b1, 1'b1);
        check("flush_valid", 32'(ex_valid), 0);
        check("flush_op", 32'(alu_op), 32'h04);
        check("flush_flags", {26'b0, inv_a, inv_b, cin, b_imm, a_zero, illegal}, 0);

        step(1'b0, 1'b1, 16'hF800, 1'b0, 1'b0);
        check("sco_sign", 32'(sign), 0);
        check("sco_op", 32'(alu_op), 32'h0D);
        step(1'b0, 1'b0, 16'hF800, 1'b0, 1'b0);
        check("bubble_valid", 32'(ex_valid), 0);
        check("bubble_sign", 32'(sign), 1);
        check("bubble_illegal", 32'(illegal), 0);

        step(1'b0, 1'b1, 16'h5810, 1'b0, 1'b0);
        check("andni_imm", 32'(ex_imm), 32'h0010);
        check("andni_invb", 32'(inv_b), 1);
        step(1'b0, 1'b1, 16'hA81F, 1'b0, 1'b0);
        check("slli_op", 32'(alu_op), 32'h01);
        check("slli_imm", 32'(ex_imm), 32'h000F);
        step(1'b0, 1'b1, 16'h6000, 1'b0, 1'b0);
        check("branch_op", 32'(alu_op), 32'h04);
        check("branch_bimm", 32'(b_imm), 0);
        step(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0);
        check("sle_op", 32'(alu_op), 32'h0C);
        step(1'b0, 1'b1, 16'hD003, 1'b0, 1'b0);
        check("srl_op", 32'(alu_op), 32'h03);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
